presc_programmable: RTL and testbench

- Run-time programmable successor to the fixed 20-bit prescaler. Divides the system clock by a loadable period, with a loadable high-time (duty).
- Produces a duty-programmable square wave `o_presc` and a one-cycle terminal tick `o_tick`.
- Two modes: continuous free-run, or one-shot (single period per start pulse).
- Feeds PWM and servo timing, display multiplexing and UART/baud tick consumers. New period/high values take effect only at a period boundary, so outputs never glitch.

---
 rtl/presc_programmable.sv | 197 +++++++++++++++++++
 tb/tb_presc_programmable.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/presc_programmable.sv
// presc_programmable: run-time programmable clock prescaler.
// Divides i_clock by a loadable period P and produces a square wave
// with a loadable high-time H plus a one-cycle tick on the last cycle
// of every period. It runs either continuously or as a one-shot.
// New P/H values are held in shadow registers and take effect only at
// a period boundary, or at once while idle, so the outputs never glitch.
module presc_programmable #(
    parameter int unsigned WIDTH          = 20,
    parameter int unsigned DEFAULT_PERIOD = 833334,
    parameter int unsigned DEFAULT_HIGH   = 416667
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_enable,
    input  logic             i_oneshot,
    input  logic             i_start,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_period,
    input  logic [WIDTH-1:0] i_high,
    output logic             o_presc,
    output logic             o_tick,
    output logic             o_busy,
    output logic             o_pending
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        ONESHOT = 2'd2
    } state_t;

    // A period below 2 cannot produce both a low and a high phase, so it
    // is raised to 2.
    function automatic logic [WIDTH-1:0] clamp_period(input logic [WIDTH-1:0] p);
        return (p < WIDTH'(2)) ? WIDTH'(2) : p;
    endfunction

    // The high-time cannot exceed the (already clamped) period. This keeps
    // P-H from underflowing.
    function automatic logic [WIDTH-1:0] clamp_high(input logic [WIDTH-1:0] h,
                                                    input logic [WIDTH-1:0] p);
        return (h > p) ? p : h;
    endfunction

    localparam logic [WIDTH-1:0] DEF_P = clamp_period(WIDTH'(DEFAULT_PERIOD));
    localparam logic [WIDTH-1:0] DEF_H = clamp_high(WIDTH'(DEFAULT_HIGH), DEF_P);

    // Reset release synchroniser. While armed is low the block stays idle
    // and ignores every input.
    logic [1:0]       sync_ff;
    logic             armed;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_nxt;

    // Active values set the current period. Shadow values are waiting to be applied.
    logic [WIDTH-1:0] act_p;
    logic [WIDTH-1:0] act_h;
    logic [WIDTH-1:0] act_p_nxt;
    logic [WIDTH-1:0] act_h_nxt;
    logic [WIDTH-1:0] sh_p;
    logic [WIDTH-1:0] sh_h;
    logic [WIDTH-1:0] sh_p_nxt;
    logic [WIDTH-1:0] sh_h_nxt;
    logic             pending_nxt;

    logic [WIDTH-1:0] cap_p;
    logic [WIDTH-1:0] cap_h;
    logic             load_ok;
    logic             wrap;
    logic             apply;
    logic             run_nxt;
    logic             presc_nxt;
    logic             tick_nxt;

    assign armed   = sync_ff[1];
    assign cap_p   = clamp_period(i_period);
    assign cap_h   = clamp_high(i_high, cap_p);
    assign load_ok = armed && i_load;
    assign wrap    = (state != IDLE) && (count == act_p - WIDTH'(1));

    // Two-flop synchroniser: assert is immediate, release takes two clock edges.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], 1'b1};
        end
    end

    // Next-state logic. The run mode (i_oneshot) is sampled only while in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (armed && i_enable) begin
                    if (!i_oneshot) begin
                        state_nxt = RUN;
                    end else if (i_start) begin
                        state_nxt = ONESHOT;
                    end
                end
            end
            RUN: begin
                if (!i_enable) begin
                    state_nxt = IDLE;
                end
            end
            ONESHOT: begin
                if (!i_enable || wrap) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Shadow capture and shadow-to-active transfer. A load on the wrap edge
    // is applied on that same edge.
    always_comb begin
        sh_p_nxt    = sh_p;
        sh_h_nxt    = sh_h;
        act_p_nxt   = act_p;
        act_h_nxt   = act_h;
        pending_nxt = o_pending;
        apply       = armed && ((state == IDLE) || wrap);
        if (load_ok) begin
            sh_p_nxt = cap_p;
            sh_h_nxt = cap_h;
        end
        if (apply) begin
            act_p_nxt   = sh_p_nxt;
            act_h_nxt   = sh_h_nxt;
            pending_nxt = 1'b0;
        end else if (load_ok) begin
            pending_nxt = 1'b1;
        end
    end

    // Counter and registered-output decode. The decode uses the post-edge
    // count and active values, so each output matches the count it is shown with.
    always_comb begin
        count_nxt = '0;
        if ((state != IDLE) && (state_nxt != IDLE) && !wrap) begin
            count_nxt = count + WIDTH'(1);
        end
        run_nxt   = (state_nxt != IDLE);
        presc_nxt = run_nxt && (count_nxt >= act_p_nxt - act_h_nxt);
        tick_nxt  = run_nxt && (count_nxt == act_p_nxt - WIDTH'(1));
    end

    // State register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter, shadow and active registers. Reset restores the default period and high-time.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count     <= '0;
            act_p     <= DEF_P;
            act_h     <= DEF_H;
            sh_p      <= DEF_P;
            sh_h      <= DEF_H;
            o_pending <= 1'b0;
        end else begin
            count     <= count_nxt;
            act_p     <= act_p_nxt;
            act_h     <= act_h_nxt;
            sh_p      <= sh_p_nxt;
            sh_h      <= sh_h_nxt;
            o_pending <= pending_nxt;
        end
    end

    // Registered outputs, so the outputs never glitch.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_presc <= 1'b0;
            o_tick  <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            o_presc <= presc_nxt;
            o_tick  <= tick_nxt;
            o_busy  <= run_nxt;
        end
    end

endmodule

// File: tb/tb_presc_programmable.sv
// Directed testbench for presc_programmable. The defaults are reduced to
// P=12, H=5 so the reset-default pattern can be observed in a short run.
// Each cycle's expected output is derived by hand from the position in
// the period.
module tb_presc_programmable;

    localparam int W = 20;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic         oneshot;
    logic         start;
    logic         load;
    logic [W-1:0] period;
    logic [W-1:0] high;
    logic         presc;
    logic         tick;
    logic         busy;
    logic         pending;

    int n_checks = 0;
    int n_errors = 0;

    presc_programmable #(
        .WIDTH(W),
        .DEFAULT_PERIOD(12),
        .DEFAULT_HIGH(5)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_enable  (enable),
        .i_oneshot (oneshot),
        .i_start   (start),
        .i_load    (load),
        .i_period  (period),
        .i_high    (high),
        .o_presc   (presc),
        .o_tick    (tick),
        .o_busy    (busy),
        .o_pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it fails.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] p, input logic [W-1:0] h);
        load = 1'b1;
        period = p;
        high = h;
        step();
        load = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        oneshot = 1'b0;
        start   = 1'b0;
        load    = 1'b0;
        period  = '0;
        high    = '0;

        // Reset state
        step(); step(); step();
        chk("rst_presc", presc, 0);
        chk("rst_tick", tick, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pending", pending, 0);
        rst_n = 1'b1;
        repeat (4) step();
        chk("idle_busy", busy, 0);

        // Defaults P=12 H=5: 7 low, 5 high, tick on count 11
        enable = 1'b1;
        step();
        for (int k = 0; k < 24; k++) begin
            chk($sformatf("def_presc[%0d]", k), presc, ((k % 12) >= 7) ? 1 : 0);
            chk($sformatf("def_tick[%0d]", k), tick, ((k % 12) == 11) ? 1 : 0);
            chk($sformatf("def_busy[%0d]", k), busy, 1);
            step();
        end
        enable = 1'b0;
        step();
        chk("def_stop_busy", busy, 0);

        // Load in IDLE applies at once: P=10 H=3
        do_load(10, 3);
        chk("idle_load_pending", pending, 0);
        enable = 1'b1;
        step();
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("small_presc[%0d]", k), presc, ((k % 10) >= 7) ? 1 : 0);
            chk($sformatf("small_tick[%0d]", k), tick, ((k % 10) == 9) ? 1 : 0);
            if (k < 19) step();
        end

        // Load coincident with the wrap edge: P=10 H=5 applies immediately
        do_load(10, 5);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("reld_presc[%0d]", k), presc, (k >= 5) ? 1 : 0);
            chk($sformatf("reld_tick[%0d]", k), tick, (k == 9) ? 1 : 0);
            chk($sformatf("reld_pending[%0d]", k), pending, (k >= 3) ? 1 : 0);
            if (k == 2) begin
                load = 1'b1;
                period = 4;
                high = 1;
            end
            step();
            load = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("new_presc[%0d]", k), presc, ((k % 4) >= 3) ? 1 : 0);
            chk($sformatf("new_tick[%0d]", k), tick, ((k % 4) == 3) ? 1 : 0);
            chk($sformatf("new_pending[%0d]", k), pending, 0);
            step();
        end

        // Disable mid-period at count 2: outputs 0 next cycle, no tick
        step(); step();
        enable = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("dis_presc[%0d]", k), presc, 0);
            chk($sformatf("dis_tick[%0d]", k), tick, 0);
            chk($sformatf("dis_busy[%0d]", k), busy, 0);
            step();
        end

        // Clamp P=1 H=0 -> P=2 H=0
        do_load(1, 0);
        enable = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("clp_presc[%0d]", k), presc, 0);
            chk($sformatf("clp_tick[%0d]", k), tick, ((k % 2) == 1) ? 1 : 0);
            step();
        end
        enable = 1'b0;
        step();

        // Clamp P=6 H=9 -> H=6, presc constantly high
        do_load(6, 9);
        enable = 1'b1;
        step();
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("clh_presc[%0d]", k), presc, 1);
            chk($sformatf("clh_tick[%0d]", k), tick, ((k % 6) == 5) ? 1 : 0);
            step();
        end
        enable = 1'b0;
        step();

        // One-shot P=8 H=2
        do_load(8, 2);
        oneshot = 1'b1;
        enable = 1'b1;
        step();
        chk("os_wait_busy0", busy, 0);
        step();
        chk("os_wait_busy1", busy, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("os_busy[%0d]", k), busy, 1);
            chk($sformatf("os_presc[%0d]", k), presc, (k >= 6) ? 1 : 0);
            chk($sformatf("os_tick[%0d]", k), tick, (k == 7) ? 1 : 0);
            if (k == 3) start = 1'b1;
            step();
            start = 1'b0;
        end
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("os_after_busy[%0d]", k), busy, 0);
            chk($sformatf("os_after_presc[%0d]", k), presc, 0);
            chk($sformatf("os_after_tick[%0d]", k), tick, 0);
            step();
        end

        // Start while disabled is ignored
        enable = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("os_dis_busy[%0d]", k), busy, 0);
            step();
        end

        // Asynchronous reset at count 5 with P=8 H=4
        do_load(8, 4);
        oneshot = 1'b0;
        enable = 1'b1;
        step();
        repeat (5) step();
        chk("pre_rst_presc", presc, 1);
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #2;
        chk("arst_presc", presc, 0);
        chk("arst_tick", tick, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pending", pending, 0);
        enable = 1'b0;
        step(); step();
        rst_n = 1'b1;
        repeat (4) step();
        enable = 1'b1;
        step();
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("rdef_presc[%0d]", k), presc, (k >= 7) ? 1 : 0);
            chk($sformatf("rdef_tick[%0d]", k), tick, (k == 11) ? 1 : 0);
            step();
        end
        enable = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
